spi_stream: RTL

//  Bus-mapped streaming reader for SPI flash. Sits directly upstream of spi_tx and drives its

---
 rtl/spi_stream.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_stream.sv
// spi_stream: streaming SPI flash reader sitting in front of spi_tx.
// Software programs a start address (W0) and a word count (W1). The block
// then issues back-to-back 32-bit READ (0x03) transactions, one at a time,
// and stores each returned word in a FIFO. Software drains the FIFO through
// R0 and reads progress through R1.
//
// Optional build macro SPI_STREAM_BSWAP_EN: byte-swap every word on push so
// that flash byte 0 lands in bits [7:0]. Without it, words are stored exactly
// as spi_tx returns them (flash byte 0 in bits [31:24]).
//
// Bus handshake: a request is accepted on the first cycle where wb_dbus_cyc
// is high, the address decodes to this block and ack is low. The register
// side effect (write, FIFO pop) happens on that cycle. ack and rdt follow one
// cycle later for exactly one cycle; rdt is 0 whenever ack is low. The master
// drops wb_dbus_cyc once it has seen ack.
module spi_stream #(
    parameter int ADDR   = 0,
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_dbus_adr,
    input  logic [31:0] wb_dbus_dat,
    input  logic        wb_dbus_we,
    input  logic        wb_dbus_cyc,
    output logic [31:0] rdt,
    output logic        ack,
    output logic [7:0]  spi_code,
    output logic [23:0] spi_addr,
    output logic        spi_tx_addr,
    output logic        spi_no_read,
    output logic        spi_req,
    input  logic [31:0] spi_rdata,
    input  logic        spi_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam logic [AWIDTH-1:0] DEC_VAL    = AWIDTH'(ADDR);
    localparam logic [LW-1:0]     FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_PUSH
    } state_t;

    // Controller state
    state_t      state_q;
    logic [23:0] addr_q;
    logic [15:0] remaining_q;
    logic        spi_req_q;
    logic        push_done_q;

    // Bus side
    logic        ack_q;
    logic [31:0] rdt_q;
    logic [31:0] rdt_d;

    // FIFO storage
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    // Address decode and register access strobes
    logic        sel;
    logic        bus_act;
    logic        bus_rd;
    logic        bus_wr;
    logic [1:0]  reg_off;
    logic        wr_start;
    logic        wr_count;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [15:0] rem_after;
    logic [31:0] push_data;
    logic [31:0] status;
    logic        busy;

    // Address and data bits this block does not decode
    logic        unused_bits;
    assign unused_bits = ^{wb_dbus_adr[31-AWIDTH:4], wb_dbus_adr[1:0], wb_dbus_dat[31:24]};

    assign sel      = (wb_dbus_adr[31 -: AWIDTH] == DEC_VAL);
    assign bus_act  = wb_dbus_cyc & sel & ~ack_q;
    assign bus_rd   = bus_act & ~wb_dbus_we;
    assign bus_wr   = bus_act & wb_dbus_we;
    assign reg_off  = wb_dbus_adr[3:2];
    assign wr_start = bus_wr & (reg_off == 2'd0);
    assign wr_count = bus_wr & (reg_off == 2'd1) & (wb_dbus_dat[15:0] != 16'd0);

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign busy       = (state_q != S_IDLE);

    // Only the first PUSH cycle writes; later PUSH cycles just wait for room.
    assign push      = (state_q == S_PUSH) & ~push_done_q;
    assign pop       = bus_rd & (reg_off == 2'd0) & ~fifo_empty;
    assign level_d   = level_q + LW'(push) - LW'(pop);
    assign rem_after = push ? (remaining_q - 16'd1) : remaining_q;

`ifdef SPI_STREAM_BSWAP_EN
    assign push_data = {spi_rdata[7:0], spi_rdata[15:8], spi_rdata[23:16], spi_rdata[31:24]};
`else
    assign push_data = spi_rdata;
`endif

    assign status = {remaining_q, 8'(level_q), 6'b0, busy, fifo_empty};

    assign rdt         = rdt_q;
    assign ack         = ack_q;
    assign spi_code    = 8'h03;
    assign spi_addr    = addr_q;
    assign spi_tx_addr = 1'b1;
    assign spi_no_read = 1'b0;
    assign spi_req     = spi_req_q;

    // Read data mux: FIFO head (0 when empty) or status; 0 otherwise
    always_comb begin
        rdt_d = '0;
        if (bus_rd) begin
            case (reg_off)
                2'd0:    rdt_d = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
                2'd1:    rdt_d = status;
                default: rdt_d = '0;
            endcase
        end
    end

    // Bus response: one-cycle ack with registered read data
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ack_q <= 1'b0;
            rdt_q <= '0;
        end else begin
            ack_q <= bus_act;
            rdt_q <= rdt_d;
        end
    end

    // Transaction sequencer: one spi_tx read in flight, never issued without FIFO room
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            spi_req_q   <= 1'b0;
            push_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_start) begin
                        addr_q <= wb_dbus_dat[23:0];
                    end
                    if (wr_count) begin
                        remaining_q <= wb_dbus_dat[15:0];
                    end
                    // spi_tx is not reset with us, so wait for it to be idle
                    if ((remaining_q != 16'd0) && spi_ready && !fifo_full) begin
                        state_q   <= S_ISSUE;
                        spi_req_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    spi_req_q <= 1'b0;
                    state_q   <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!spi_ready) begin
                        state_q <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (spi_ready) begin
                        state_q     <= S_PUSH;
                        push_done_q <= 1'b0;
                    end
                end
                S_PUSH: begin
                    if (!push_done_q) begin
                        addr_q      <= addr_q + 24'd4;
                        remaining_q <= remaining_q - 16'd1;
                        push_done_q <= 1'b1;
                    end
                    if (rem_after == 16'd0) begin
                        state_q <= S_IDLE;
                    end else if (level_d != FULL_LEVEL) begin
                        state_q   <= S_ISSUE;
                        spi_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    spi_req_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers and level; push and pop in one cycle leave the level unchanged
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule
